// File: rtl/regfile_pkg.sv
// Shared defaults and packed-bus index helper for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_WR   = 2;
  localparam int DEF_ZERO_REG = 1;

  // LSB position of field `port` inside a bus of fields each `width` bits wide.
  function automatic int lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus registered pending count; updates on the clock edge.
// No backpressure: issues and writes are always accepted, and an issue beats a same-cycle write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    pend_nxt = pending;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) pend_nxt[wr_addr[lsb(j, ADDR_W) +: ADDR_W]] = 1'b0;
    end
    // Issue is applied after the clears so a fresh producer keeps the bit set.
    if (iss_en) pend_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;

    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a producer scoreboard.
// Reads are zero-latency combinational; writes/issues take effect at the edge; no backpressure.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .wr_en    (wr_en_i),
    .wr_addr  (wr_addr_i),
    .iss_en   (iss_en_i),
    .iss_addr (iss_addr_i),
    .pending  (pending),
    .pend_cnt (pend_cnt_o)
  );

  // Ports are visited in ascending order so the highest-index write wins a collision.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] &&
            !((ZERO_REG != 0) && (wr_addr_i[lsb(j, ADDR_W) +: ADDR_W] == '0))) begin
          regs[wr_addr_i[lsb(j, ADDR_W) +: ADDR_W]] <= wr_data_i[lsb(j, DATA_W) +: DATA_W];
        end
      end
    end
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rval;
  logic              hit;

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
    rval      = '0;
    hit       = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = rd_addr_i[lsb(k, ADDR_W) +: ADDR_W];
      rval = regs[ra];
      hit  = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[lsb(j, ADDR_W) +: ADDR_W] == ra)) begin
          rval = wr_data_i[lsb(j, DATA_W) +: DATA_W];
          hit  = 1'b1;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) rval = '0;
      // Outputs are forced quiet while reset is held, independent of inputs.
      rd_data_o[lsb(k, DATA_W) +: DATA_W] = rst_i ? rval : '0;
      rd_busy_o[k] = rst_i && pending[ra] && !hit;
    end
  end

endmodule
